// File: rtl/apb_data_bridge_if.sv
// APB bus bundle between the data bridge (master) and four APB slaves.
// Each slave has its own PRDATA/PREADY return path; the request side is shared.
interface apb_data_bridge_if;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [3:0]  PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
   logic        PREADY0, PREADY1, PREADY2, PREADY3;

   modport master (
      output PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
      input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
      input  PREADY0, PREADY1, PREADY2, PREADY3
   );

   modport slave (
      input  PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE,
      output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
      output PREADY0, PREADY1, PREADY2, PREADY3
   );
endinterface

// File: rtl/apb_data_bridge.sv
// Core data port to 4-slave APB bridge: decodes 0x1000_0000..0x1000_3FFF,
// does byte/half lane steering and load extension, aborts slow slaves after TIMEOUT.
module apb_data_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   d_req,
   input  logic                   d_wr_en,
   input  logic [31:0]            dAddr,
   input  logic [31:0]            dWdata,
   input  logic [2:0]             extend_controls,
   output logic [31:0]            dRdata,
   output logic                   d_ready,
   output logic                   d_err,
   apb_data_bridge_if.master      apb
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt;
   logic [1:0]  idx_q;
   logic [1:0]  lo_q;
   logic [2:0]  ext_q;
   logic        decode_hit;
   logic        sel_ready;
   logic [31:0] sel_rdata;
   logic [31:0] lane_shifted;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic        is_byte, is_half;
   logic        timeout_hit;

   assign decode_hit  = (dAddr[31:28] == 4'h1) && (dAddr[27:14] == '0);
   assign is_byte     = (extend_controls == 3'b000) || (extend_controls == 3'b100);
   assign is_half     = (extend_controls == 3'b001) || (extend_controls == 3'b101);
   assign timeout_hit = (state == ACCESS) && !sel_ready && (wait_cnt == TIMEOUT_CNT);

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      case (idx_q)
         2'd0: begin sel_ready = apb.PREADY0; sel_rdata = apb.PRDATA0; end
         2'd1: begin sel_ready = apb.PREADY1; sel_rdata = apb.PRDATA1; end
         2'd2: begin sel_ready = apb.PREADY2; sel_rdata = apb.PRDATA2; end
         default: begin sel_ready = apb.PREADY3; sel_rdata = apb.PRDATA3; end
      endcase
   end

   // Lane extraction uses the registered address bits, not the live dAddr.
   assign lane_shifted = sel_rdata >> {lo_q, 3'b000};
   assign half_sel     = lo_q[1] ? sel_rdata[31:16] : sel_rdata[15:0];

   always_comb begin
      load_val = sel_rdata;
      case (ext_q)
         3'b000:  load_val = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
         3'b100:  load_val = {24'h0, lane_shifted[7:0]};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'h0, half_sel};
         default: load_val = sel_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      apb.PSEL    = '0;
      apb.PENABLE = 1'b0;
      d_ready     = 1'b0;
      case (state)
         IDLE:   if (d_req) state_nxt = decode_hit ? SETUP : DONE;
         SETUP: begin
            apb.PSEL  = 4'b0001 << idx_q;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            apb.PSEL    = 4'b0001 << idx_q;
            apb.PENABLE = 1'b1;
            if (sel_ready || timeout_hit) state_nxt = DONE;
         end
         DONE: begin
            d_ready   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt   <= '0;
         idx_q      <= '0;
         lo_q       <= '0;
         ext_q      <= '0;
         apb.PADDR  <= '0;
         apb.PWRITE <= 1'b0;
         apb.PWDATA <= '0;
         apb.PSTRB  <= '0;
         dRdata     <= '0;
         d_err      <= 1'b0;
      end else begin
         if (state == ACCESS && !sel_ready) wait_cnt <= wait_cnt + 8'd1;
         else                               wait_cnt <= '0;

         if (state == IDLE && d_req) begin
            idx_q      <= dAddr[13:12];
            lo_q       <= dAddr[1:0];
            ext_q      <= extend_controls;
            apb.PADDR  <= {dAddr[31:2], 2'b00};
            apb.PWRITE <= d_wr_en;
            if (!d_wr_en)     apb.PSTRB <= '0;
            else if (is_byte) apb.PSTRB <= 4'b0001 << dAddr[1:0];
            else if (is_half) apb.PSTRB <= dAddr[1] ? 4'b1100 : 4'b0011;
            else              apb.PSTRB <= 4'b1111;
            if (is_byte)      apb.PWDATA <= {4{dWdata[7:0]}};
            else if (is_half) apb.PWDATA <= {2{dWdata[15:0]}};
            else              apb.PWDATA <= dWdata;
            if (!decode_hit) begin
               dRdata <= '0;
               d_err  <= 1'b1;
            end
         end

         if (state == ACCESS) begin
            if (sel_ready) begin
               dRdata <= apb.PWRITE ? '0 : load_val;
               d_err  <= 1'b0;
            end else if (timeout_hit) begin
               dRdata <= '0;
               d_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_data_bridge.sv
// Directed bench for apb_data_bridge (TIMEOUT=4) with a simple four-slave APB model.
module tb_apb_data_bridge;
   logic        clk, reset, d_req, d_wr_en;
   logic [31:0] dAddr, dWdata, dRdata;
   logic [2:0]  extend_controls;
   logic        d_ready, d_err;

   apb_data_bridge_if bus();

   apb_data_bridge #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .d_req(d_req), .d_wr_en(d_wr_en),
      .dAddr(dAddr), .dWdata(dWdata), .extend_controls(extend_controls),
      .dRdata(dRdata), .d_ready(d_ready), .d_err(d_err), .apb(bus.master)
   );

   logic [31:0] rd [4];
   logic [3:0]  ready_en;
   int unsigned wait_n;
   int unsigned acc_cnt = 0;

   // Slave raises PREADY after wait_n ACCESS cycles, if enabled.
   always @(posedge clk) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
   assign bus.PRDATA0 = rd[0];
   assign bus.PRDATA1 = rd[1];
   assign bus.PRDATA2 = rd[2];
   assign bus.PRDATA3 = rd[3];
   assign bus.PREADY0 = ready_en[0] && (acc_cnt >= wait_n);
   assign bus.PREADY1 = ready_en[1] && (acc_cnt >= wait_n);
   assign bus.PREADY2 = ready_en[2] && (acc_cnt >= wait_n);
   assign bus.PREADY3 = ready_en[3] && (acc_cnt >= wait_n);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   int          lat;
   logic [3:0]  c_psel, c_pstrb, post_psel;
   logic [31:0] c_paddr, c_pwdata;
   logic        c_pwrite, pen_s, pen_a, post_ready;

   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] ext);
      @(negedge clk);
      d_req = 1'b1; d_wr_en = wr; dAddr = a; dWdata = wd; extend_controls = ext;
      lat = 0; c_psel = '0; c_pstrb = '0; c_paddr = '0; c_pwdata = '0; c_pwrite = 1'b0;
      pen_s = 1'b0; pen_a = 1'b0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) pen_s = bus.PENABLE;
         if (lat == 2) pen_a = bus.PENABLE;
         if (bus.PSEL != 0 && c_psel == 0) begin
            c_psel = bus.PSEL; c_paddr = bus.PADDR; c_pstrb = bus.PSTRB;
            c_pwdata = bus.PWDATA; c_pwrite = bus.PWRITE;
         end
      end while (!d_ready && lat < 20);
      chk("ready_seen", {31'b0, d_ready}, 32'd1);
      d_req = 1'b0;
      @(posedge clk); #1;
      post_ready = d_ready;
      post_psel  = bus.PSEL;
   endtask

   initial begin
      d_req = 0; d_wr_en = 0; dAddr = '0; dWdata = '0; extend_controls = '0;
      rd[0] = '0; rd[1] = '0; rd[2] = '0; rd[3] = '0;
      ready_en = 4'hF; wait_n = 0;
      reset = 1'b1;
      #3 reset = 1'b0;
      #2;
      chk("rst_psel", bus.PSEL, 4'h0);
      chk("rst_penable", bus.PENABLE, 1'b0);
      chk("rst_paddr", bus.PADDR, 32'h0);
      chk("rst_pwdata", bus.PWDATA, 32'h0);
      chk("rst_pstrb", bus.PSTRB, 4'h0);
      chk("rst_pwrite", bus.PWRITE, 1'b0);
      chk("rst_drdata", dRdata, 32'h0);
      chk("rst_dready", d_ready, 1'b0);
      chk("rst_derr", d_err, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Load word from slave 2
      rd[2] = 32'hDEAD_BEEF;
      xfer(1'b0, 32'h1000_2008, 32'h0, 3'b010);
      chk("lw_lat", lat, 3);
      chk("lw_psel", c_psel, 4'b0100);
      chk("lw_paddr", c_paddr, 32'h1000_2008);
      chk("lw_pstrb", c_pstrb, 4'h0);
      chk("lw_pwrite", c_pwrite, 1'b0);
      chk("lw_pen_setup", pen_s, 1'b0);
      chk("lw_pen_access", pen_a, 1'b1);
      chk("lw_data", dRdata, 32'hDEAD_BEEF);
      chk("lw_err", d_err, 1'b0);
      chk("lw_ready_one_cycle", post_ready, 1'b0);
      chk("lw_psel_after", post_psel, 4'h0);
      chk("lw_data_held", dRdata, 32'hDEAD_BEEF);

      // Stores: byte, half, word
      xfer(1'b1, 32'h1000_1003, 32'h0000_00A5, 3'b000);
      chk("sb_pstrb", c_pstrb, 4'b1000);
      chk("sb_pwdata", c_pwdata, 32'hA5A5_A5A5);
      chk("sb_pwrite", c_pwrite, 1'b1);
      chk("sb_psel", c_psel, 4'b0010);
      chk("sb_paddr", c_paddr, 32'h1000_1000);
      chk("sb_lat", lat, 3);
      xfer(1'b1, 32'h1000_0003, 32'h1234_BEEF, 3'b001);
      chk("sh_pstrb", c_pstrb, 4'b1100);
      chk("sh_pwdata", c_pwdata, 32'hBEEF_BEEF);
      chk("sh_psel", c_psel, 4'b0001);
      xfer(1'b1, 32'h1000_3004, 32'h1122_3344, 3'b010);
      chk("sw_pstrb", c_pstrb, 4'b1111);
      chk("sw_pwdata", c_pwdata, 32'h1122_3344);
      chk("sw_psel", c_psel, 4'b1000);
      chk("sw_paddr", c_paddr, 32'h1000_3004);

      // Load extension
      rd[0] = 32'h0000_8000;
      xfer(1'b0, 32'h1000_0001, 32'h0, 3'b000);
      chk("lb_data", dRdata, 32'hFFFF_FF80);
      chk("lb_paddr", c_paddr, 32'h1000_0000);
      xfer(1'b0, 32'h1000_0001, 32'h0, 3'b100);
      chk("lbu_data", dRdata, 32'h0000_0080);
      rd[1] = 32'h8001_1234;
      xfer(1'b0, 32'h1000_1002, 32'h0, 3'b001);
      chk("lh_data", dRdata, 32'hFFFF_8001);
      xfer(1'b0, 32'h1000_1002, 32'h0, 3'b101);
      chk("lhu_data", dRdata, 32'h0000_8001);
      xfer(1'b0, 32'h1000_1000, 32'h0, 3'b001);
      chk("lh_low_data", dRdata, 32'h0000_1234);

      // Unsupported access codes behave as word
      xfer(1'b0, 32'h1000_0001, 32'h0, 3'b011);
      chk("l011_data", dRdata, 32'h0000_8000);
      xfer(1'b1, 32'h1000_0001, 32'hCAFE_F00D, 3'b111);
      chk("s111_pstrb", c_pstrb, 4'b1111);
      chk("s111_pwdata", c_pwdata, 32'hCAFE_F00D);

      // Decode errors
      xfer(1'b0, 32'h2000_0000, 32'h0, 3'b010);
      chk("derr_lat", lat, 1);
      chk("derr_psel", c_psel, 4'h0);
      chk("derr_err", d_err, 1'b1);
      chk("derr_data", dRdata, 32'h0);
      xfer(1'b1, 32'h1000_4000, 32'h5555_5555, 3'b010);
      chk("derr2_lat", lat, 1);
      chk("derr2_psel", c_psel, 4'h0);
      chk("derr2_err", d_err, 1'b1);

      // Two wait states
      wait_n = 2;
      rd[2] = 32'h0BAD_F00D;
      xfer(1'b0, 32'h1000_2000, 32'h0, 3'b010);
      chk("ws_lat", lat, 5);
      chk("ws_data", dRdata, 32'h0BAD_F00D);
      chk("ws_err", d_err, 1'b0);
      wait_n = 0;

      // Timeout on slave 3
      ready_en = 4'b0111;
      rd[3] = 32'hFFFF_FFFF;
      xfer(1'b0, 32'h1000_3000, 32'h0, 3'b010);
      chk("to_lat", lat, 7);
      chk("to_psel", c_psel, 4'b1000);
      chk("to_err", d_err, 1'b1);
      chk("to_data", dRdata, 32'h0);
      chk("to_psel_after", post_psel, 4'h0);

      // Reset during ACCESS
      @(negedge clk);
      d_req = 1'b1; d_wr_en = 1'b0; dAddr = 32'h1000_3000; extend_controls = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      chk("mr_psel_pre", bus.PSEL, 4'b1000);
      reset = 1'b0;
      #1;
      chk("mr_psel", bus.PSEL, 4'h0);
      chk("mr_penable", bus.PENABLE, 1'b0);
      chk("mr_dready", d_ready, 1'b0);
      d_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      begin
         logic seen;
         seen = 1'b0;
         repeat (5) begin
            @(posedge clk); #1;
            if (d_ready) seen = 1'b1;
         end
         chk("mr_no_ready", seen, 1'b0);
      end
      ready_en = 4'hF;
      xfer(1'b0, 32'h1000_2008, 32'h0, 3'b010);
      chk("mr_next_lat", lat, 3);
      chk("mr_next_data", dRdata, 32'h0BAD_F00D);
      chk("mr_next_err", d_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/apb_data_bridge.md
APB_DATA_BRIDGE -- requirements
Module: apb_data_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max ACCESS-phase wait cycles before abort; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port d_req  input  1  core data-access request, held with its qualifiers until d_ready.
REQ-005 SHALL have port d_wr_en  input  1  1=store, 0=load.
REQ-006 SHALL have port dAddr  input  32  byte address.
REQ-007 SHALL have port dWdata  input  32  store data, LSB-justified.
REQ-008 SHALL have port extend_controls  input  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port dRdata  output  32  extended load data.
REQ-010 SHALL have port d_ready  output  1  one-cycle completion strobe.
REQ-011 SHALL have port d_err  output  1  error flag, valid with d_ready.
REQ-012 SHALL have ports PADDR output 32, PWRITE output 1, PWDATA output 32, PSTRB output 4, PSEL output 4 (one-hot), PENABLE output 1.
REQ-013 SHALL have ports PRDATA0..PRDATA3 input 32 each, PREADY0..PREADY3 input 1 each.

Function
REQ-014 Decode SHALL hit only when dAddr[31:28]=4'h1 and dAddr[27:14]=0; slave index = dAddr[13:12]; every other address is a decode error.
REQ-015 FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-016 IDLE: d_req=1 and decode hit -> SETUP; d_req=1 and decode miss -> DONE with error; otherwise stay.
REQ-017 SETUP SHALL drive PSEL[index]=1, PENABLE=0, and advance to ACCESS unconditionally.
REQ-018 ACCESS SHALL drive PSEL[index]=1, PENABLE=1; selected PREADY=1 -> DONE (data latched); else stay and increment the wait counter.
REQ-019 ACCESS SHALL abort to DONE with error when the wait counter reaches TIMEOUT without PREADY; PSEL and PENABLE deassert on the following cycle.
REQ-020 DONE SHALL assert d_ready=1 for exactly one cycle, then return to IDLE; a d_req still high in that IDLE is treated as a new request.
REQ-021 Latency SHALL be 3 cycles from first sampled d_req to d_ready with zero-wait slave; +1 per PREADY=0 cycle; 1 cycle for decode error.
REQ-022 Address, write flag, data, strobes and access type SHALL be registered in IDLE on acceptance and held constant through SETUP/ACCESS.
REQ-023 PADDR SHALL be {dAddr[31:2],2'b00}; misaligned low bits beyond access size are ignored (H uses addr[1] only).
REQ-024 Store PSTRB: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],0}; W -> 4'b1111; loads SHALL drive PSTRB=0.
REQ-025 Store PWDATA: B -> byte replicated x4; H -> halfword replicated x2; W -> unchanged.
REQ-026 Load dRdata SHALL be selected lane of latched PRDATA[index], shifted to bit 0, sign-extended (B,H) or zero-extended (BU,HU, W unchanged).
REQ-027 Unsupported extend_controls codes (011,110,111) SHALL be treated as W.
REQ-028 On error d_err=1 and dRdata=0; no PSEL SHALL be asserted for a decode error.
REQ-029 dRdata and d_err SHALL hold value from DONE until next DONE; outside DONE d_ready=0.
REQ-030 PSEL SHALL never have more than one bit set; PENABLE=1 only in ACCESS.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, wait counter 0, and all outputs 0 (PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA, dRdata, d_ready, d_err).
REQ-032 reset asserted mid-transfer SHALL drop PSEL/PENABLE asynchronously; no d_ready is issued for the aborted request.
REQ-033 After reset release the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-034 Load W dAddr=0x1000_2008, PRDATA2=0xDEAD_BEEF, PREADY2=1 -> PSEL=4'b0100, PADDR=0x1000_2008, d_ready at cycle 3, dRdata=0xDEAD_BEEF, d_err=0.
REQ-035 Store B dAddr=0x1000_1003, dWdata=0x0000_00A5 -> PSTRB=4'b1000, PWDATA=0xA5A5_A5A5, PWRITE=1, PSEL=4'b0010.
REQ-036 Load B and BU at 0x1000_0001, PRDATA0=0x0000_8000 -> dRdata=0xFFFF_FF80 (B), 0x0000_0080 (BU).
REQ-037 Access dAddr=0x2000_0000 -> no PSEL, d_ready after 1 cycle, d_err=1, dRdata=0.
REQ-038 TIMEOUT=4, PREADY3 held 0 -> d_ready with d_err=1 after ACCESS waits 4 cycles, PSEL cleared after.
REQ-039 reset=0 during ACCESS with PREADY=0 -> PSEL=0 immediately, no d_ready; next request completes normally.
